// File: rtl/fifo_rd_stream.sv
// Read-side adapter: pulls words from a 1-cycle-latency FIFO into a 3-entry skid
// buffer and presents them as a valid/ready stream.
module fifo_rd_stream #(
    parameter int unsigned DATA_WIDTH = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_fifo_empty,
    output logic                  o_fifo_rd_en,
    input  logic [DATA_WIDTH-1:0] i_fifo_rd_data,
    input  logic                  i_flush,
    output logic                  o_valid,
    output logic [DATA_WIDTH-1:0] o_data,
    input  logic                  i_ready,
    output logic [1:0]            o_level
);

    logic [DATA_WIDTH-1:0] mem_q [3];
    logic [1:0]            wptr_q, wptr_d;
    logic [1:0]            rptr_q, rptr_d;
    logic [1:0]            cnt_q, cnt_d;
    logic                  f_q;
    logic                  en_q;
    logic                  push, pop;

    function automatic logic [1:0] ptr_inc(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    // en_q keeps reads off until the first edge after reset release.
    assign o_fifo_rd_en = en_q && !i_fifo_empty && !i_flush &&
                          (({1'b0, cnt_q} + {2'b00, f_q}) < 3'd3);
    assign o_valid      = (cnt_q != 2'd0);
    assign o_data       = o_valid ? mem_q[rptr_q] : '0;
    assign o_level      = cnt_q;

    // A word returning during a flush cycle is dropped along with the buffer.
    assign push = f_q && !i_flush;
    assign pop  = o_valid && i_ready;

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        if (i_flush) begin
            wptr_d = 2'd0;
            rptr_d = 2'd0;
            cnt_d  = 2'd0;
        end else begin
            if (push) wptr_d = ptr_inc(wptr_q);
            if (pop)  rptr_d = ptr_inc(rptr_q);
            unique case ({push, pop})
                2'b10:   cnt_d = cnt_q + 2'd1;
                2'b01:   cnt_d = cnt_q - 2'd1;
                default: cnt_d = cnt_q;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < 3; i++) mem_q[i] <= '0;
            wptr_q <= 2'd0;
            rptr_q <= 2'd0;
            cnt_q  <= 2'd0;
            f_q    <= 1'b0;
            en_q   <= 1'b0;
        end else begin
            if (push) mem_q[wptr_q] <= i_fifo_rd_data;
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
            f_q    <= o_fifo_rd_en;
            en_q   <= 1'b1;
        end
    end

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Bench for fifo_rd_stream: behavioural source FIFO, scoreboard of issued reads,
// per-cycle tables for backpressure/empty boundary, hand sequences for flush/reset.
module tb_fifo_rd_stream;

    logic       i_clk = 1'b0;
    logic       i_rst_n;
    logic       i_fifo_empty;
    logic       o_fifo_rd_en;
    logic [3:0] i_fifo_rd_data;
    logic       i_flush;
    logic       o_valid;
    logic [3:0] o_data;
    logic       i_ready;
    logic [1:0] o_level;

    fifo_rd_stream #(.DATA_WIDTH(4)) dut (
        .i_clk          (i_clk),
        .i_rst_n        (i_rst_n),
        .i_fifo_empty   (i_fifo_empty),
        .o_fifo_rd_en   (o_fifo_rd_en),
        .i_fifo_rd_data (i_fifo_rd_data),
        .i_flush        (i_flush),
        .o_valid        (o_valid),
        .o_data         (o_data),
        .i_ready        (i_ready),
        .o_level        (o_level)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic       ready;
        logic       exp_rd;
        logic       exp_valid;
        logic [3:0] exp_data;
        logic [1:0] exp_level;
    } row_t;

    int n_vec = 0;
    int n_miss = 0;
    int n_out = 0;
    logic [3:0] src[$];
    logic [3:0] exp_q[$];
    logic       pend_v = 1'b0;
    logic [3:0] pend_d = '0;
    logic       stall_v = 1'b0;
    logic [3:0] stall_d = '0;

    task automatic check(input string name, input int act, input int req);
        n_vec++;
        if (act != req) begin
            n_miss++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Drive this cycle's inputs at the falling edge, then sample and score.
    task automatic drive_sample();
        i_fifo_empty   = (src.size() == 0);
        i_fifo_rd_data = pend_v ? pend_d : 4'h0;
        pend_v         = 1'b0;
        #1;
        if (o_valid && stall_v) check("stall_hold", o_data, stall_d);
        stall_v = o_valid && !i_ready && !i_flush;
        stall_d = o_data;
        if (o_valid && i_ready && !i_flush) begin
            if (exp_q.size() == 0) check("unexpected_word", o_data, -1);
            else check("stream_data", o_data, exp_q.pop_front());
            n_out++;
        end
        if (i_flush) exp_q.delete();
        if (o_fifo_rd_en) begin
            if (i_fifo_empty || i_flush) check("rd_en_gate", 1, 0);
            if (src.size() != 0) begin
                pend_d = src.pop_front();
                pend_v = 1'b1;
                exp_q.push_back(pend_d);
            end
        end
    endtask

    task automatic advance();
        @(posedge i_clk);
        @(negedge i_clk);
    endtask

    task automatic run_row(input row_t r, input string tag);
        i_ready = r.ready;
        drive_sample();
        check({tag, "_rd_en"}, o_fifo_rd_en, r.exp_rd);
        check({tag, "_valid"}, o_valid, r.exp_valid);
        check({tag, "_data"},  o_data, r.exp_data);
        check({tag, "_level"}, o_level, r.exp_level);
        advance();
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_rd_en"}, o_fifo_rd_en, 0);
        check({tag, "_valid"}, o_valid, 0);
        check({tag, "_data"},  o_data, 0);
        check({tag, "_level"}, o_level, 0);
    endtask

    task automatic drain(input int cycles);
        i_ready = 1'b1;
        for (int i = 0; i < cycles; i++) begin
            drive_sample();
            advance();
        end
    endtask

    row_t bp [11];
    row_t eb [4];

    initial begin
        int first_rd, first_val, run, k;
        logic done;

        // ready, rd_en, valid, data, level
        bp[0]  = '{1'b0, 1'b1, 1'b0, 4'h0, 2'd0};
        bp[1]  = '{1'b0, 1'b1, 1'b0, 4'h0, 2'd0};
        bp[2]  = '{1'b0, 1'b1, 1'b1, 4'hA, 2'd1};
        bp[3]  = '{1'b0, 1'b0, 1'b1, 4'hA, 2'd2};
        bp[4]  = '{1'b0, 1'b0, 1'b1, 4'hA, 2'd3};
        bp[5]  = '{1'b0, 1'b0, 1'b1, 4'hA, 2'd3};
        bp[6]  = '{1'b1, 1'b0, 1'b1, 4'hA, 2'd3};
        bp[7]  = '{1'b1, 1'b1, 1'b1, 4'hB, 2'd2};
        bp[8]  = '{1'b1, 1'b0, 1'b1, 4'hC, 2'd1};
        bp[9]  = '{1'b1, 1'b0, 1'b1, 4'hD, 2'd1};
        bp[10] = '{1'b1, 1'b0, 1'b0, 4'h0, 2'd0};
        eb[0]  = '{1'b1, 1'b1, 1'b0, 4'h0, 2'd0};
        eb[1]  = '{1'b1, 1'b0, 1'b0, 4'h0, 2'd0};
        eb[2]  = '{1'b1, 1'b0, 1'b1, 4'h5, 2'd1};
        eb[3]  = '{1'b1, 1'b0, 1'b0, 4'h0, 2'd0};

        i_rst_n = 1'b0; i_fifo_empty = 1'b0; i_fifo_rd_data = '0;
        i_flush = 1'b0; i_ready = 1'b0;
        @(negedge i_clk);
        @(negedge i_clk);
        check_zero("reset");
        i_rst_n = 1'b1;
        advance();

        // Streaming 0x1..0x8 with ready held high.
        for (int i = 1; i <= 8; i++) src.push_back(4'(i));
        i_ready = 1'b1; first_rd = -1; first_val = -1; run = 0; done = 1'b0;
        for (int c = 0; c < 30; c++) begin
            drive_sample();
            if (o_fifo_rd_en && first_rd < 0) first_rd = c;
            if (o_valid) begin
                if (first_val < 0) first_val = c;
                if (!done) run++;
            end else if (run > 0) done = 1'b1;
            advance();
        end
        check("stream_latency", first_val - first_rd, 2);
        check("stream_run", run, 8);
        check("stream_all_out", exp_q.size(), 0);

        // Backpressure with 0xA..0xD, then release.
        src = '{4'hA, 4'hB, 4'hC, 4'hD};
        for (int i = 0; i < 11; i++) run_row(bp[i], $sformatf("bp%0d", i));
        check("bp_all_out", exp_q.size(), 0);

        // Single word at the empty boundary.
        src = '{4'h5};
        for (int i = 0; i < 4; i++) run_row(eb[i], $sformatf("eb%0d", i));

        // Flush with level 2 and a read in flight.
        src = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5};
        i_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin drive_sample(); advance(); end
        i_flush = 1'b1;
        drive_sample();
        check("flush_pre_level", o_level, 2);
        check("flush_rd_en", o_fifo_rd_en, 0);
        advance();
        i_flush = 1'b0;
        drive_sample();
        check("flush_valid", o_valid, 0);
        check("flush_level", o_level, 0);
        advance();
        n_out = 0;
        drain(12);
        check("flush_after_words", n_out, 2);
        check("flush_all_out", exp_q.size(), 0);

        // Reset mid-stream at level 2.
        src = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6};
        i_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin drive_sample(); advance(); end
        drive_sample();
        check("rst_pre_level", o_level, 2);
        i_rst_n = 1'b0;
        #1;
        check_zero("rst_mid");
        exp_q.delete(); pend_v = 1'b0; stall_v = 1'b0;
        advance();
        drive_sample();
        check_zero("rst_hold");
        advance();
        i_rst_n = 1'b1;
        advance();
        n_out = 0;
        drain(12);
        check("rst_after_words", n_out, 3);
        check("rst_all_out", exp_q.size(), 0);

        // Random ready toggling over 64 words.
        for (int i = 0; i < 64; i++) src.push_back(4'($urandom_range(0, 15)));
        n_out = 0; k = 0;
        while ((src.size() != 0 || exp_q.size() != 0) && k < 2000) begin
            i_ready = 1'($urandom_range(0, 1));
            drive_sample();
            advance();
            k++;
        end
        check("rand_timeout", (k < 2000) ? 1 : 0, 1);
        check("rand_words", n_out, 64);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/fifo_rd_stream.md
FIFO_RD_STREAM -- requirements
Module: fifo_rd_stream

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 4: width of FIFO read data and output stream data.
REQ-002 SHALL have port i_clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port i_rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have port i_fifo_empty  input  1  FIFO empty flag, read-clock domain.
REQ-005 SHALL have port o_fifo_rd_en  output  1  FIFO read request.
REQ-006 SHALL have port i_fifo_rd_data  input  DATA_WIDTH  FIFO read data, valid exactly 1 cycle after an accepted o_fifo_rd_en.
REQ-007 SHALL have port i_flush  input  1  synchronous discard of all buffered and in-flight words.
REQ-008 SHALL have port o_valid  output  1  stream word available.
REQ-009 SHALL have port o_data  output  DATA_WIDTH  stream word.
REQ-010 SHALL have port i_ready  input  1  downstream accepts word when o_valid=1.
REQ-011 SHALL have port o_level  output  2  number of words held in the internal buffer (0..3).

Function
REQ-012 SHALL hold an internal 3-entry circular buffer (registers) with write pointer, read pointer, and count.
REQ-013 SHALL track an in-flight flag f: set when o_fifo_rd_en=1; cleared otherwise.
REQ-014 SHALL drive o_fifo_rd_en = !i_fifo_empty && !i_flush && (count + f < 3), computed from registered state only; no combinational path from i_ready to o_fifo_rd_en.
REQ-015 SHALL write i_fifo_rd_data into the buffer at the edge ending the cycle after o_fifo_rd_en=1, unless discarded per REQ-021.
REQ-016 SHALL drive o_valid = (count != 0) and o_data = buffer entry at read pointer; o_data is 0 when count = 0.
REQ-017 SHALL pop one word on each edge where o_valid && i_ready; read pointer advances by 1, wrapping 2->0.
REQ-018 SHALL keep o_data stable while o_valid && !i_ready.
REQ-019 SHALL, on simultaneous push and pop, leave count unchanged and advance both pointers.
REQ-020 SHALL preserve FIFO order; no word duplicated or lost except by flush.
REQ-021 SHALL, on i_flush=1, set count, pointers to 0 at that edge and discard the word returning from a read issued in the flush cycle or the cycle before; o_valid=0 from the next cycle.
REQ-022 SHALL sustain one word per cycle when FIFO non-empty and i_ready held 1; first o_valid 2 cycles after first o_fifo_rd_en.
REQ-023 SHALL never exceed count 3; count + f <= 3 at all times.
REQ-024 SHALL drive o_level = count.

Reset
REQ-025 SHALL, while i_rst_n=0, force count=0, pointers=0, f=0, discard flag=0, o_valid=0, o_data=0, o_level=0, o_fifo_rd_en=0, regardless of i_fifo_empty.
REQ-026 SHALL, on reset assertion mid-operation, drop all buffered and in-flight words; first read after release issued no earlier than the first edge with i_rst_n=1.

Verification
REQ-027 Streaming: FIFO holds 0x1..0x8, i_ready=1 -> o_data 0x1..0x8 in order on 8 consecutive cycles, o_valid high first 2 cycles after first rd_en.
REQ-028 Backpressure: FIFO holds 0xA,0xB,0xC,0xD, i_ready=0 -> o_fifo_rd_en stops after 3 reads, o_level=3, o_data held 0xA; release i_ready -> 0xA,0xB,0xC,0xD delivered.
REQ-029 Empty boundary: one word 0x5 written, i_ready=1 -> exactly one rd_en pulse, one o_valid cycle with 0x5, then o_valid=0, o_level=0.
REQ-030 Flush: o_level=2 with read in flight, pulse i_flush -> o_valid=0 next cycle, in-flight word not output, next FIFO word delivered after flush.
REQ-031 Reset mid-stream: assert i_rst_n=0 with o_level=2 -> all outputs 0 immediately; after release streaming resumes from next FIFO word.
REQ-032 Random i_ready toggling with 64 words -> output sequence equals input sequence, o_data stable under stall.
